// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - shared barrier gate arbiter for entry/exit lanes with occupancy tracking
module parking_gate_arbiter #(
  parameter int CAPACITY       = 8,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int TMR_W          = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             entryReq,
  input  logic             exitReq,
  input  logic             passOk,
  input  logic             sensorB,
  output logic             entryGrant,
  output logic             gateOpen,
  output logic             timeoutAlarm,
  output logic             lotFull,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_ENTRY,
    OPEN_ENTRY,
    OPEN_EXIT,
    CLOSE,
    ALARM
  } state_t;

  localparam logic [CNT_W-1:0] CAP_VAL  = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           nextState;
  logic [TMR_W-1:0] timer;
  // 1 = the most recent service (closed or timed out) was the entry lane
  logic             lastServedEntry;
  logic             validEntry;
  logic             validExit;
  logic             isOpen;
  logic             leavingOpen;

  assign lotFull     = (occupancy == CAP_VAL);
  assign validEntry  = entryReq & ~lotFull;
  assign validExit   = exitReq;
  assign isOpen      = (state == OPEN_ENTRY) || (state == OPEN_EXIT);
  assign leavingOpen = isOpen && (nextState != state);

  // Next-state selection and state-decoded outputs
  always_comb begin
    nextState    = state;
    entryGrant   = 1'b0;
    gateOpen     = 1'b0;
    timeoutAlarm = 1'b0;
    case (state)
      IDLE: begin
        if (validEntry && validExit) begin
          // round-robin: serve the lane that did not go last
          nextState = lastServedEntry ? OPEN_EXIT : GRANT_ENTRY;
        end else if (validEntry) begin
          nextState = GRANT_ENTRY;
        end else if (validExit) begin
          nextState = OPEN_EXIT;
        end
      end
      GRANT_ENTRY: begin
        entryGrant = 1'b1;
        if (passOk) begin
          nextState = OPEN_ENTRY;
        end else if (!entryReq) begin
          nextState = IDLE;
        end
      end
      OPEN_ENTRY, OPEN_EXIT: begin
        gateOpen = 1'b1;
        // a car crossing on the last allowed cycle still counts as a pass
        if (sensorB) begin
          nextState = CLOSE;
        end else if (timer == TMR_LAST) begin
          nextState = ALARM;
        end
      end
      CLOSE: begin
        nextState = IDLE;
      end
      ALARM: begin
        timeoutAlarm = 1'b1;
        if (!entryReq && !exitReq && !sensorB) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Open-gate timer: counts only while staying in an OPEN state, zero otherwise
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timer <= '0;
    end else if (isOpen && (nextState == state)) begin
      timer <= timer + TMR_W'(1);
    end else begin
      timer <= '0;
    end
  end

  // Direction of the service just finished; also drives the CLOSE update
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lastServedEntry <= 1'b0;
    end else if (leavingOpen) begin
      lastServedEntry <= (state == OPEN_ENTRY);
    end
  end

  // Occupancy update on a completed passage, saturating at both ends
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      occupancy <= '0;
    end else if (state == CLOSE) begin
      if (lastServedEntry) begin
        if (occupancy != CAP_VAL) begin
          occupancy <= occupancy + CNT_W'(1);
        end
      end else if (occupancy != '0) begin
        occupancy <= occupancy - CNT_W'(1);
      end
    end
  end

endmodule
